// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 scan-code decoder: two-player direction keys, Space/Escape strobes, last byte.
// Define PS2_REVERSE_BLOCK_EN to ignore requests for the direction opposite the current one.
module ps2_cmd_decoder #(
    parameter logic [1:0] P1_INIT_DIR = 2'b01,
    parameter logic [1:0] P2_INIT_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       dir_init,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       start_pulse,
    output logic       esc_pulse,
    output logic [7:0] last_code
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

`ifdef PS2_REVERSE_BLOCK_EN
    localparam bit REV_BLOCK = 1'b1;
`else
    localparam bit REV_BLOCK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t     state;
    logic       space_held;
    logic       esc_held;

    logic       p1_hit;
    logic [1:0] p1_req;
    logic       p2_hit;
    logic [1:0] p2_req;

    // A 180-degree turn keeps the current heading when reversal blocking is built in.
    function automatic logic [1:0] next_dir(input logic [1:0] cur, input logic [1:0] req);
        return (REV_BLOCK && (req == (cur ^ 2'b10))) ? cur : req;
    endfunction

    always_comb begin
        p1_hit = 1'b0;
        p1_req = DIR_UP;
        p2_hit = 1'b0;
        p2_req = DIR_UP;
        case (scan_code)
            8'h1D: begin p1_hit = 1'b1; p1_req = DIR_UP;    end
            8'h1B: begin p1_hit = 1'b1; p1_req = DIR_DOWN;  end
            8'h1C: begin p1_hit = 1'b1; p1_req = DIR_LEFT;  end
            8'h23: begin p1_hit = 1'b1; p1_req = DIR_RIGHT; end
            8'h75: begin p2_hit = 1'b1; p2_req = DIR_UP;    end
            8'h72: begin p2_hit = 1'b1; p2_req = DIR_DOWN;  end
            8'h6B: begin p2_hit = 1'b1; p2_req = DIR_LEFT;  end
            8'h74: begin p2_hit = 1'b1; p2_req = DIR_RIGHT; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            p1_dir      <= P1_INIT_DIR;
            p2_dir      <= P2_INIT_DIR;
            start_pulse <= 1'b0;
            esc_pulse   <= 1'b0;
            last_code   <= 8'h00;
            space_held  <= 1'b0;
            esc_held    <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            esc_pulse   <= 1'b0;

            if (scan_ready) begin
                if (scan_code != CODE_EXT && scan_code != CODE_BRK)
                    last_code <= scan_code;

                case (state)
                    BRK, EXT_BRK: begin
                        if (scan_code == CODE_SPACE) space_held <= 1'b0;
                        if (scan_code == CODE_ESC)   esc_held   <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        if (scan_code == CODE_EXT) begin
                            state <= (state == IDLE) ? EXT : IDLE;
                        end else if (scan_code == CODE_BRK) begin
                            state <= (state == IDLE) ? BRK : EXT_BRK;
                        end else begin
                            state <= IDLE;
                            // Player-2 arrows arrive with or without the E0 prefix.
                            if (p2_hit)
                                p2_dir <= next_dir(p2_dir, p2_req);
                            if (state == IDLE) begin
                                if (p1_hit)
                                    p1_dir <= next_dir(p1_dir, p1_req);
                                if (scan_code == CODE_SPACE) begin
                                    start_pulse <= !space_held;
                                    space_held  <= 1'b1;
                                end
                                if (scan_code == CODE_ESC) begin
                                    esc_pulse <= !esc_held;
                                    esc_held  <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end

            // Placed last so it overrides any direction byte in the same cycle.
            if (dir_init) begin
                p1_dir <= P1_INIT_DIR;
                p2_dir <= P2_INIT_DIR;
            end
        end
    end

endmodule
